// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 32'd0;
  localparam int unsigned MODE_SAT  = 32'd1;

  // Bits needed to hold prescaler values 0..presc-1, never less than one.
  function automatic int unsigned presc_width(input int unsigned presc);
    if (presc <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(presc);
    end
  endfunction

endpackage

// File: rtl/mod_updown_counter_prescaler.sv
// Enable prescaler: emits one step per PRESCALE enabled cycles; clr discards a partial count.
module enable_prescaler
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  generate
    if (PRESCALE == 32'd1) begin : g_pass
      logic unused_s;
      assign unused_s = &{1'b0, clk, rst, clr};
      assign step     = en;
    end else begin : g_div
      localparam int unsigned PW = presc_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 32'd1);

      logic [PW-1:0] presc_r;

      // Prescale counter: clears on reset or load, wraps after the stepping cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          presc_r <= {PW{1'b0}};
        end else if (clr) begin
          presc_r <= {PW{1'b0}};
        end else if (en) begin
          if (presc_r == LAST) begin
            presc_r <= {PW{1'b0}};
          end else begin
            presc_r <= presc_r + PW'(1);
          end
        end else begin
          presc_r <= presc_r;
        end
      end

      assign step = en & ~clr & (presc_r == LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with load, prescaled enable, wrap/saturate bounds
// and a registered terminal-count pulse.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (32'd1 << WIDTH) - 32'd1,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic             SAT_B  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_r;
  logic             tick_r;
  logic             step_s;
  logic             boundary_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] ld_clamp_s;

  enable_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (ld),
    .en  (en),
    .step(step_s)
  );

  assign at_max = (count_r == MAX_W);
  assign at_min = (count_r == ZERO_W);
  assign count  = count_r;
  assign tick   = tick_r;

  // Next-value and boundary detection for a step in the sampled direction.
  always_comb begin
    next_s     = count_r;
    boundary_s = 1'b0;
    ld_clamp_s = (ld_val > MAX_W) ? MAX_W : ld_val;
    if (up == DIR_UP) begin
      if (count_r == MAX_W) begin
        boundary_s = 1'b1;
        next_s     = SAT_B ? MAX_W : ZERO_W;
      end else begin
        next_s = count_r + WIDTH'(1);
      end
    end else begin
      if (count_r == ZERO_W) begin
        boundary_s = 1'b1;
        next_s     = SAT_B ? ZERO_W : MAX_W;
      end else begin
        next_s = count_r - WIDTH'(1);
      end
    end
  end

  // Count and terminal-count registers; rst beats ld beats a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= ZERO_W;
      tick_r  <= 1'b0;
    end else if (ld) begin
      count_r <= ld_clamp_s;
      tick_r  <= 1'b0;
    end else if (step_s) begin
      count_r <= next_s;
      tick_r  <= boundary_s;
    end else begin
      count_r <= count_r;
      tick_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: four counter configurations (wrap, saturate, prescale 3, prescale 4).
module tb_mod_updown_counter;

  logic       clk;
  logic [3:0] rst, en, up, ld;
  logic [3:0] ld_val [4];
  logic [3:0] count  [4];
  logic [3:0] tick, at_max, at_min;
  int tests;
  int fails;

  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up(up[0]), .ld(ld[0]), .ld_val(ld_val[0]),
    .count(count[0]), .tick(tick[0]), .at_max(at_max[0]), .at_min(at_min[0]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up(up[1]), .ld(ld[1]), .ld_val(ld_val[1]),
    .count(count[1]), .tick(tick[1]), .at_max(at_max[1]), .at_min(at_min[1]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(0)) u_p3 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up(up[2]), .ld(ld[2]), .ld_val(ld_val[2]),
    .count(count[2]), .tick(tick[2]), .at_max(at_max[2]), .at_min(at_min[2]));
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(4), .SATURATE(0)) u_p4 (
    .clk(clk), .rst(rst[3]), .en(en[3]), .up(up[3]), .ld(ld[3]), .ld_val(ld_val[3]),
    .count(count[3]), .tick(tick[3]), .at_max(at_max[3]), .at_min(at_min[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 4'hF; en = 4'h0; up = 4'h0; ld = 4'h0;
    for (int k = 0; k < 4; k++) ld_val[k] = 4'd0;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("rst_count", int'(count[k]), 0);
      chk("rst_tick", int'(tick[k]), 0);
      chk("rst_at_min", int'(at_min[k]), 1);
      chk("rst_at_max", int'(at_max[k]), 0);
    end

    // up-wrap
    rst[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("wrap_count", int'(count[0]), i % 10);
      chk("wrap_tick", int'(tick[0]), (i == 10) ? 1 : 0);
      if (i == 9) chk("wrap_at_max", int'(at_max[0]), 1);
    end

    // down-wrap
    rst[0] = 1'b1; cyc();
    rst[0] = 1'b0; up[0] = 1'b0;
    cyc(); chk("dn_count9", int'(count[0]), 9); chk("dn_tick9", int'(tick[0]), 1);
    chk("dn_at_max", int'(at_max[0]), 1);
    cyc(); chk("dn_count8", int'(count[0]), 8); chk("dn_tick8", int'(tick[0]), 0);
    cyc(); chk("dn_count7", int'(count[0]), 7); chk("dn_tick7", int'(tick[0]), 0);
    en[0] = 1'b0;
    cyc(); chk("hold_count", int'(count[0]), 7); chk("hold_tick", int'(tick[0]), 0);

    // load clamp and priority over en
    ld[0] = 1'b1; ld_val[0] = 4'd15; en[0] = 1'b1; up[0] = 1'b1;
    cyc(); chk("ld_clamp", int'(count[0]), 9); chk("ld_clamp_tick", int'(tick[0]), 0);
    ld_val[0] = 4'd3;
    cyc(); chk("ld_nostep", int'(count[0]), 3);
    ld_val[0] = 4'd9;
    cyc(); chk("ld_9", int'(count[0]), 9);
    cyc(); chk("ld_at_max_hold", int'(count[0]), 9); chk("ld_no_tick", int'(tick[0]), 0);
    ld[0] = 1'b0;
    cyc(); chk("after_ld_wrap", int'(count[0]), 0); chk("after_ld_tick", int'(tick[0]), 1);
    cyc(); chk("after_ld_count1", int'(count[0]), 1);
    rst[0] = 1'b1; ld[0] = 1'b1; ld_val[0] = 4'd5;
    cyc(); chk("rst_over_ld", int'(count[0]), 0); chk("rst_over_ld_tick", int'(tick[0]), 0);
    rst[0] = 1'b0; ld[0] = 1'b0; en[0] = 1'b0;

    // saturate
    rst[1] = 1'b0; ld[1] = 1'b1; ld_val[1] = 4'd8;
    cyc(); chk("sat_ld", int'(count[1]), 8);
    ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
    cyc(); chk("sat_to9", int'(count[1]), 9); chk("sat_to9_tick", int'(tick[1]), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sat_hold", int'(count[1]), 9);
      chk("sat_hold_tick", int'(tick[1]), 1);
      chk("sat_at_max", int'(at_max[1]), 1);
    end
    up[1] = 1'b0;
    cyc(); chk("sat_dn8", int'(count[1]), 8); chk("sat_dn8_tick", int'(tick[1]), 0);
    rst[1] = 1'b1; cyc();
    rst[1] = 1'b0;
    cyc(); chk("sat_lo", int'(count[1]), 0); chk("sat_lo_tick", int'(tick[1]), 1);
    chk("sat_at_min", int'(at_min[1]), 1);
    cyc(); chk("sat_lo2", int'(count[1]), 0); chk("sat_lo2_tick", int'(tick[1]), 1);
    en[1] = 1'b0;

    // prescale 3
    rst[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("p3_count", int'(count[2]), i / 3);
      chk("p3_tick", int'(tick[2]), 0);
    end
    cyc(); cyc(); chk("p3_mid", int'(count[2]), 2);
    en[2] = 1'b0;
    cyc(); chk("p3_gap1", int'(count[2]), 2);
    cyc(); chk("p3_gap2", int'(count[2]), 2);
    en[2] = 1'b1;
    cyc(); chk("p3_delayed", int'(count[2]), 3);
    cyc(); chk("p3_partial", int'(count[2]), 3);
    ld[2] = 1'b1; ld_val[2] = 4'd5;
    cyc(); chk("p3_ld", int'(count[2]), 5);
    ld[2] = 1'b0;
    cyc(); chk("p3_ld_e1", int'(count[2]), 5);
    cyc(); chk("p3_ld_e2", int'(count[2]), 5);
    cyc(); chk("p3_ld_e3", int'(count[2]), 6);
    en[2] = 1'b0;

    // prescale 4: direction change mid-prescale, then reset mid-prescale
    rst[3] = 1'b0; ld[3] = 1'b1; ld_val[3] = 4'd5;
    cyc(); chk("p4_ld", int'(count[3]), 5);
    ld[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b1;
    cyc(); cyc(); chk("p4_e2", int'(count[3]), 5);
    up[3] = 1'b0;
    cyc(); chk("p4_e3", int'(count[3]), 5);
    cyc(); chk("p4_dec", int'(count[3]), 4); chk("p4_dec_tick", int'(tick[3]), 0);
    up[3] = 1'b1;
    cyc(); cyc(); chk("p4_pre_rst", int'(count[3]), 4);
    rst[3] = 1'b1;
    cyc(); chk("p4_rst", int'(count[3]), 0);
    rst[3] = 1'b0;
    cyc(); cyc(); cyc(); chk("p4_rst_e3", int'(count[3]), 0);
    cyc(); chk("p4_rst_e4", int'(count[3]), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
